uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of byte entries (power of 2, 2..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, width of the occupancy count.
REQ-003 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx_data  input  8  byte from the upstream UART receiver.
REQ-006 SHALL have port rx_rdy  input  1  level, upstream byte valid until cleared.
REQ-007 SHALL have port clr_rdy  output  1  registered one-cycle pulse that clears upstream rdy.
REQ-008 SHALL have port rd_en  input  1  pop request from the bus side.
REQ-009 SHALL have port rd_data  output  8  head entry (show-ahead); 8'h00 when empty.
REQ-010 SHALL have port empty  output  1  no entries.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port count  output  CNT_W  current occupancy.
REQ-013 SHALL have port ovr  output  1  sticky overrun flag.
REQ-014 SHALL have port ovr_clr  input  1  clears ovr.
REQ-015 SHALL have port wmark  input  CNT_W  watermark level.
REQ-016 SHALL have port irq  output  1  watermark interrupt.

Function
REQ-017 SHALL capture a byte on the edge where rx_rdy==1 and clr_rdy==0 (capture event).
REQ-018 SHALL drive clr_rdy=1 for exactly the cycle after each capture event, then 0.
REQ-019 SHALL, on a capture event with full==0 or a simultaneous pop, write rx_data at wr_ptr and advance wr_ptr modulo DEPTH.
REQ-020 SHALL, on a capture event with full==1 and no pop, drop the byte, leave contents unchanged, set ovr=1, and still pulse clr_rdy.
REQ-021 SHALL, on rd_en==1 with empty==0, advance rd_ptr modulo DEPTH; rd_data updates the next cycle.
REQ-022 SHALL ignore rd_en when empty==1; no pointer or count change, no error flag.
REQ-023 SHALL, on simultaneous push and pop, keep count unchanged; when empty, push only.
REQ-024 SHALL update count, empty and full registered, in the same cycle as the pointer change.
REQ-025 SHALL give priority to set when ovr_clr and an overrun coincide (ovr ends at 1).
REQ-026 SHALL have one-cycle latency from capture event to empty deasserting and rd_data valid.
REQ-027 SHALL never capture the same upstream byte twice.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear wr_ptr, rd_ptr, count, ovr, clr_rdy and irq, and set empty=1, full=0.
REQ-029 SHALL not reset the storage array; rd_data reads 8'h00 while empty.
REQ-030 SHALL, if reset is asserted mid-handshake, leave clr_rdy=0 and recapture any byte still pending upstream after release.

Configuration
REQ-031 SHALL compile the watermark interrupt only when UART_RX_WMARK_EN is defined.
REQ-032 SHALL, with UART_RX_WMARK_EN defined, register irq=1 while count>=wmark and wmark!=0, else 0.
REQ-033 SHALL, without UART_RX_WMARK_EN, keep the wmark port, ignore it, and tie irq to 0.

Verification
REQ-034 SHALL cover: reset, then rx_rdy=1 with rx_data=8'hA5 -> one clr_rdy pulse, count=1, rd_data=8'hA5 one cycle later.
REQ-035 SHALL cover: push 8 bytes 8'h01..8'h08 -> full=1, count=8; 8 pops -> data in order, empty=1.
REQ-036 SHALL cover: full, then push 8'hFF -> ovr=1, contents unchanged, clr_rdy pulses; ovr_clr -> ovr=0.
REQ-037 SHALL cover: full, push and pop in the same cycle -> count stays 8, the new byte is read last.
REQ-038 SHALL cover: with UART_RX_WMARK_EN and wmark=3, third push -> irq=1; one pop -> irq=0.
REQ-039 SHALL cover: rd_en while empty -> no change; rst_n pulse mid-stream -> count=0, empty=1, ovr=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO between a UART receiver (rdy/clr handshake) and a
// bus-side reader. Show-ahead read port, sticky overrun flag, occupancy count.
// Optional watermark interrupt compiled in when UART_RX_WMARK_EN is defined;
// otherwise the wmark port is present but ignored and irq is tied low.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_rdy,
    output logic             clr_rdy,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             ovr,
    input  logic             ovr_clr,
    input  logic [CNT_W-1:0] wmark,
    output logic             irq
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage is deliberately not reset; rd_data is masked while empty.
    logic [7:0]       mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             empty_q;
    logic             full_q;
    logic             clr_rdy_q;
    logic             ovr_q;

    logic             capture;
    logic             pop;
    logic             push;
    logic             overrun;

    // Handshake decode and next occupancy. A byte is taken only when the
    // upstream flag is up and we are not already clearing it, so the byte
    // whose rdy is still high during the clr_rdy cycle is never taken twice.
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // byte when it is being read at the same time.
    always_comb begin
        capture   = rx_rdy & ~clr_rdy_q;
        pop       = rd_en & ~empty_q;
        push      = capture & (~full_q | pop);
        overrun   = capture & full_q & ~pop;
        count_nxt = count_q;
        if (push && !pop) begin
            count_nxt = count_q + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count_q - 1'b1;
        end
    end

    // Pointers, count and flags move together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == CNT_W'(DEPTH));
        end
    end

    // Byte storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // One-cycle clear pulse after every capture, including dropped bytes.
    // Reset forces it low so a byte still pending upstream is taken again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_rdy_q <= 1'b0;
        end else begin
            clr_rdy_q <= capture;
        end
    end

    // Sticky overrun: a new overrun wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (overrun) begin
            ovr_q <= 1'b1;
        end else if (ovr_clr) begin
            ovr_q <= 1'b0;
        end
    end

    assign clr_rdy = clr_rdy_q;
    assign ovr     = ovr_q;
    assign count   = count_q;
    assign empty   = empty_q;
    assign full    = full_q;
    assign rd_data = empty_q ? 8'h00 : mem[rd_ptr];

`ifdef UART_RX_WMARK_EN
    logic irq_q;

    // Watermark level compare on the next count so irq tracks count exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (wmark != '0) && (count_nxt >= wmark);
        end
    end

    assign irq = irq_q;
`else
    logic unused_wmark;

    assign unused_wmark = ^wmark;
    assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard queue.
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_rdy = 1'b0;
    logic             clr_rdy;
    logic             rd_en = 1'b0;
    logic [7:0]       rd_data;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             ovr;
    logic             ovr_clr = 1'b0;
    logic [CNT_W-1:0] wmark = '0;
    logic             irq;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sb[$];
    logic       ovr_m = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .clr_rdy (clr_rdy),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovr     (ovr),
        .ovr_clr (ovr_clr),
        .wmark   (wmark),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_irq();
`ifdef UART_RX_WMARK_EN
        return (wmark != '0) && (sb.size() >= int'(wmark));
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_status(input string tag);
        logic [7:0] head;
        head = (sb.size() != 0) ? sb[0] : 8'h00;
        chk({tag, ".count"},   32'(count),   32'(sb.size()));
        chk({tag, ".empty"},   32'(empty),   32'(sb.size() == 0));
        chk({tag, ".full"},    32'(full),    32'(sb.size() == DEPTH));
        chk({tag, ".ovr"},     32'(ovr),     32'(ovr_m));
        chk({tag, ".rd_data"}, 32'(rd_data), 32'(head));
        chk({tag, ".irq"},     32'(irq),     32'(exp_irq()));
    endtask

    // Upstream presents a byte; rdy stays high through the clr_rdy cycle.
    task automatic send_byte(input logic [7:0] b, input logic clr);
        rx_data = b;
        rx_rdy  = 1'b1;
        ovr_clr = clr;
        step();
        ovr_clr = 1'b0;
        chk("clr_rdy_pulse", 32'(clr_rdy), 32'd1);
        if (sb.size() < DEPTH) begin
            sb.push_back(b);
        end else begin
            ovr_m = 1'b1;
        end
        chk_status("push");
        step();
        chk("clr_rdy_low", 32'(clr_rdy), 32'd0);
        chk_status("no_dup");
        rx_rdy = 1'b0;
    endtask

    task automatic pop_byte();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        if (sb.size() != 0) begin
            void'(sb.pop_front());
        end
        chk_status("pop");
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst.clr_rdy", 32'(clr_rdy), 32'd0);
        chk_status("rst");
        rst_n = 1'b1;
        step();
        chk_status("post_rst");

        // Single byte
        send_byte(8'hA5, 1'b0);
        pop_byte();

        // Fill to full, in order
        for (int i = 1; i <= DEPTH; i++) begin
            send_byte(8'(i), 1'b0);
        end

        // Overrun drops the byte and sets ovr; clear it
        send_byte(8'hFF, 1'b0);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        ovr_m   = 1'b0;
        chk_status("ovr_clr");

        // Overrun coinciding with clear: set wins
        send_byte(8'hEE, 1'b1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        ovr_m   = 1'b0;
        chk_status("ovr_clr2");

        // Push and pop together while full
        rx_data = 8'h99;
        rx_rdy  = 1'b1;
        rd_en   = 1'b1;
        step();
        rd_en = 1'b0;
        void'(sb.pop_front());
        sb.push_back(8'h99);
        chk("pp.clr_rdy", 32'(clr_rdy), 32'd1);
        chk_status("push_pop");
        step();
        rx_rdy = 1'b0;
        chk("pp.clr_low", 32'(clr_rdy), 32'd0);
        chk_status("push_pop2");

        // Drain: 02..08 then 99
        for (int i = 0; i < DEPTH; i++) begin
            pop_byte();
        end

        // Read while empty has no effect
        pop_byte();
        pop_byte();

        // Watermark
        wmark = CNT_W'(3);
        step();
        chk_status("wm0");
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b0);
        pop_byte();
        send_byte(8'h34, 1'b0);

        // Reset mid-handshake with a byte still pending upstream
        ovr_m   = 1'b0;
        rx_data = 8'h77;
        rx_rdy  = 1'b1;
        step();
        chk("mid.clr_rdy", 32'(clr_rdy), 32'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("rst_mid.clr_rdy", 32'(clr_rdy), 32'd0);
        chk_status("rst_mid");
        #2;
        rst_n = 1'b1;
        step();
        sb.push_back(8'h77);
        chk("recap.clr_rdy", 32'(clr_rdy), 32'd1);
        chk_status("recap");
        step();
        rx_rdy = 1'b0;
        chk("recap.clr_low", 32'(clr_rdy), 32'd0);
        chk_status("recap2");
        pop_byte();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
